reg_bank_exec: RTL

- Receiving end of the controller's toggle-signalled command interface in the 8-bit nRisc core.
- Detects each toggle of in_signal and captures op, index_a, index_b and data.
- Executes the command against an internal bank of eight 8-bit registers, running data-memory accesses through a req/ack handshake.
- Returns completion to the controller as a toggle on ack_signal.

---
 rtl/nrisc_pkg.sv | 24 ++
 rtl/nrisc_alu.sv | 26 ++
 rtl/reg_bank_exec.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/nrisc_pkg.sv
// Shared types and constants for the nRisc command executor.
// Opcodes, FSM state encoding, data and register-index widths.
package nrisc_pkg;

  localparam int DW = 8;
  localparam int IW = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_LI  = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_BEQ = 3'b110;
  localparam logic [2:0] OP_BNZ = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MEM_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/nrisc_alu.sv
// Combinational ALU: op/a/b -> 8-bit result plus branch condition.
// Ports: op, a, b in; result, cond out. Arithmetic wraps modulo 256.
module nrisc_alu
  import nrisc_pkg::*;
(
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          cond
);

  always_comb begin
    result = a;
    cond   = 1'b0;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_MUL: result = a * b;
      OP_BEQ: cond   = (a == b);
      OP_BNZ: cond   = (a != '0);
      default: result = a;
    endcase
  end

endmodule

// File: rtl/reg_bank_exec.sv
// Toggle-signalled command executor with an 8x8 register bank and
// req/ack data-memory port. Inputs: clock, reset, in_signal, op,
// index_a, index_b, data_in, mem_rdata, mem_ack. Outputs: ack_signal,
// busy, branch_taken, mem_req, mem_we, mem_addr, mem_wdata, error.
// Macro RB_DEBUG_PORT_EN adds dbg_index in / dbg_data out.
module reg_bank_exec
  import nrisc_pkg::*;
#(
  parameter int            MEM_TIMEOUT   = 15,
  parameter logic [DW-1:0] REG_RESET_VAL = 8'h00
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_signal,
  input  logic [2:0]    op,
  input  logic [IW-1:0] index_a,
  input  logic [IW-1:0] index_b,
  input  logic [DW-1:0] data_in,
  output logic          ack_signal,
  output logic          busy,
  output logic          branch_taken,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          error
`ifdef RB_DEBUG_PORT_EN
  ,
  input  logic [IW-1:0] dbg_index,
  output logic [DW-1:0] dbg_data
`endif
);

  state_t        state;
  state_t        state_d;
  logic [DW-1:0] regs [8];
  logic          last_signal;
  logic          pending;
  logic [3:0]    cnt;
  logic [2:0]    op_q;
  logic [IW-1:0] a_q;
  logic [IW-1:0] b_q;
  logic [DW-1:0] d_q;

  logic          new_cmd;
  logic          capture;
  logic          is_mem;
  logic          is_br;
  logic          timeout;
  logic [DW-1:0] alu_res;
  logic          alu_cond;
  logic [DW-1:0] wr_val;

  assign new_cmd = (in_signal != last_signal);
  assign is_mem  = (op_q == OP_LW) || (op_q == OP_SW);
  assign is_br   = (op_q == OP_BEQ) || (op_q == OP_BNZ);
  assign timeout = (cnt == 4'(MEM_TIMEOUT - 1));
  assign wr_val  = (op_q == OP_LI) ? d_q : alu_res;

`ifdef RB_DEBUG_PORT_EN
  assign dbg_data = regs[dbg_index];
`endif

  nrisc_alu u_alu (
    .op     (op_q),
    .a      (regs[a_q]),
    .b      (regs[b_q]),
    .result (alu_res),
    .cond   (alu_cond)
  );

  always_comb begin
    state_d = state;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (new_cmd || pending) begin
          capture = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC:     state_d = is_mem ? MEM_WAIT : DONE;
      MEM_WAIT: if (mem_ack || timeout) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= REG_RESET_VAL;
      state        <= IDLE;
      last_signal  <= in_signal;
      pending      <= 1'b0;
      cnt          <= '0;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      d_q          <= '0;
      ack_signal   <= 1'b0;
      busy         <= 1'b0;
      branch_taken <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      error        <= 1'b0;
    end else begin
      last_signal  <= in_signal;
      state        <= state_d;
      branch_taken <= 1'b0;
      // Overrun: one command may queue behind the running one;
      // a further toggle is lost and flagged.
      if (new_cmd && state != IDLE) begin
        if (pending) error <= 1'b1;
        else pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (capture) begin
            op_q    <= op;
            a_q     <= index_a;
            b_q     <= index_b;
            d_q     <= data_in;
            busy    <= 1'b1;
            // A toggle landing as the queued command starts stays queued.
            pending <= pending & new_cmd;
          end
        end
        EXEC: begin
          if (is_mem) begin
            mem_req   <= 1'b1;
            mem_we    <= (op_q == OP_SW);
            mem_addr  <= regs[b_q];
            mem_wdata <= regs[a_q];
            cnt       <= '0;
          end else if (is_br) begin
            branch_taken <= alu_cond;
          end else begin
            regs[a_q] <= wr_val;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) regs[a_q] <= mem_rdata;
          end else if (timeout) begin
            mem_req <= 1'b0;
            error   <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          ack_signal <= ~ack_signal;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
